// File: rtl/telemetry_csr_ctrl.sv
// telemetry_csr_ctrl
//   Bus-side controller for the telemetry counter block (mcycle, minstret, stall).
//   It presents the 64-bit counters as 32-bit registers behind a valid/ready
//   request/response port. LO reads take a coherent snapshot. Writes load the
//   counters or update CTRL/STATUS. It also drives the counter enable.
//   Optional feature macro: TELEM_OVF_IRQ_EN. It enables overflow STATUS and irq.
//   With the macro undefined, STATUS reads 0 and irq is tied low.
module telemetry_csr_ctrl #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [2:0]       req_addr,
   input  logic [31:0]      req_wdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_rdata,
   input  logic             dbg_halt,
   input  logic [WIDTH-1:0] cnt_mcycle,
   input  logic [WIDTH-1:0] cnt_minstret,
   input  logic [WIDTH-1:0] cnt_stall,
   output logic             cycle_en,
   output logic [2:0]       cnt_ld,
   output logic             cnt_ld_hi,
   output logic [31:0]      cnt_ld_data,
   output logic             irq
);

   localparam logic [2:0] ADDR_CTRL   = 3'd6;
   localparam logic [2:0] ADDR_STATUS = 3'd7;

`ifdef TELEM_OVF_IRQ_EN
   localparam int LATCH_W = 3;   // CTRL bits plus STATUS clear bits
`else
   localparam int LATCH_W = 2;   // CTRL bits only
`endif

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_RESP = 2'd2} state_t;

   state_t             r_state;
   logic               r_req_ready;
   logic               r_rsp_valid;
   logic [31:0]        r_rsp_rdata;
   logic               r_we;
   logic [2:0]         r_addr;
   logic [LATCH_W-1:0] r_wdata;
   logic [2:0]         r_cnt_ld;
   logic               r_cnt_ld_hi;
   logic [31:0]        r_cnt_ld_data;
   logic [1:0]         r_ctrl;        // [0] INH, [1] HALT_FREEZE
   logic [WIDTH-1:0]   r_shadow [3];
   logic [2:0]         r_shv;         // shadow valid per counter

   logic [WIDTH-1:0]   w_live;
   logic [WIDTH-1:0]   w_shadow;
   logic               w_shv;
   logic [63:0]        w_live_ext;
   logic [63:0]        w_shadow_ext;
   logic [2:0]         w_sel;
   logic [2:0]         w_status;
   logic [31:0]        w_rd_data;

   // One-hot counter select from the word-pair index; indices 3 (CTRL/STATUS) select nothing.
   function automatic logic [2:0] sel3(input logic [1:0] idx);
      logic [2:0] s;
      case (idx)
         2'd0:    s = 3'b001;
         2'd1:    s = 3'b010;
         2'd2:    s = 3'b100;
         default: s = 3'b000;
      endcase
      return s;
   endfunction

   assign w_sel = sel3(r_addr[2:1]);

   // Select the addressed counter and its shadow, then form the read data.
   always_comb begin
      w_live   = '0;
      w_shadow = '0;
      w_shv    = 1'b0;
      case (r_addr[2:1])
         2'd0: begin
            w_live   = cnt_mcycle;
            w_shadow = r_shadow[0];
            w_shv    = r_shv[0];
         end
         2'd1: begin
            w_live   = cnt_minstret;
            w_shadow = r_shadow[1];
            w_shv    = r_shv[1];
         end
         2'd2: begin
            w_live   = cnt_stall;
            w_shadow = r_shadow[2];
            w_shv    = r_shv[2];
         end
         default: begin
            w_live   = '0;
            w_shadow = '0;
            w_shv    = 1'b0;
         end
      endcase
      // Zero-extend to 64 so HI words of narrower counters read upper zeros.
      w_live_ext   = 64'(w_live);
      w_shadow_ext = 64'(w_shadow);
      case (r_addr)
         3'd0, 3'd2, 3'd4: w_rd_data = w_live_ext[31:0];
         3'd1, 3'd3, 3'd5: w_rd_data = w_shv ? w_shadow_ext[63:32] : w_live_ext[63:32];
         ADDR_CTRL:        w_rd_data = {30'd0, r_ctrl};
         ADDR_STATUS:      w_rd_data = {29'd0, w_status};
         default:          w_rd_data = 32'd0;
      endcase
   end

   // Request/response FSM with registered outputs, CTRL register and snapshot shadows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_req_ready   <= 1'b1;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= 32'd0;
         r_we          <= 1'b0;
         r_addr        <= 3'd0;
         r_wdata       <= '0;
         r_cnt_ld      <= 3'b000;
         r_cnt_ld_hi   <= 1'b0;
         r_cnt_ld_data <= 32'd0;
         r_ctrl        <= 2'b10;
         r_shv         <= 3'b000;
         for (int i = 0; i < 3; i++) begin
            r_shadow[i] <= '0;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid && r_req_ready) begin
                  r_req_ready <= 1'b0;
                  r_we        <= req_we;
                  r_addr      <= req_addr;
                  r_wdata     <= req_wdata[LATCH_W-1:0];
                  r_state     <= ST_EXEC;
                  // Load strobe is raised here so it is high for exactly the EXEC cycle.
                  if (req_we && (req_addr < ADDR_CTRL)) begin
                     r_cnt_ld      <= sel3(req_addr[2:1]);
                     r_cnt_ld_hi   <= req_addr[0];
                     r_cnt_ld_data <= req_wdata;
                  end
               end
            end
            ST_EXEC: begin
               r_cnt_ld    <= 3'b000;
               r_rsp_valid <= 1'b1;
               r_rsp_rdata <= r_we ? 32'd0 : w_rd_data;
               r_state     <= ST_RESP;
               if (r_we && (r_addr == ADDR_CTRL)) begin
                  r_ctrl <= r_wdata[1:0];
               end
               // LO read captures a snapshot; HI read or any load invalidates it.
               if (w_sel != 3'b000) begin
                  if (!r_we && !r_addr[0]) begin
                     r_shv <= r_shv | w_sel;
                  end else begin
                     r_shv <= r_shv & ~w_sel;
                  end
               end
               for (int i = 0; i < 3; i++) begin
                  if (w_sel[i] && !r_we && !r_addr[0]) begin
                     r_shadow[i] <= w_live;
                  end
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_req_ready <= 1'b1;
               r_rsp_valid <= 1'b0;
               r_cnt_ld    <= 3'b000;
            end
         endcase
      end
   end

`ifdef TELEM_OVF_IRQ_EN
   logic [2:0] r_msb_prev;
   logic [2:0] r_ld_prev;
   logic [2:0] r_status;
   logic       r_irq;
   logic [2:0] w_msb_now;
   logic [2:0] w_wrap;
   logic [2:0] w_status_clr;
   logic [2:0] w_status_nxt;

   assign w_msb_now = {cnt_stall[WIDTH-1], cnt_minstret[WIDTH-1], cnt_mcycle[WIDTH-1]};
   // A 1->0 MSB transition is a wrap unless it was caused by a load.
   assign w_wrap    = r_msb_prev & ~w_msb_now & ~r_ld_prev;
   assign w_status_clr = (r_state == ST_EXEC && r_we && r_addr == ADDR_STATUS) ? r_wdata : 3'b000;
   // Set has priority over a same-cycle write-1-to-clear.
   assign w_status_nxt = (r_status & ~w_status_clr) | w_wrap;

   // Overflow tracking: MSB history, load history, sticky STATUS and registered irq.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_msb_prev <= 3'b000;
         r_ld_prev  <= 3'b000;
         r_status   <= 3'b000;
         r_irq      <= 1'b0;
      end else begin
         r_msb_prev <= w_msb_now;
         r_ld_prev  <= r_cnt_ld;
         r_status   <= w_status_nxt;
         r_irq      <= |w_status_nxt;
      end
   end

   assign w_status = r_status;
   assign irq      = r_irq;
`else
   assign w_status = 3'b000;
   assign irq      = 1'b0;
`endif

   assign cycle_en    = !r_ctrl[0] && !(r_ctrl[1] && dbg_halt);
   assign req_ready   = r_req_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign cnt_ld      = r_cnt_ld;
   assign cnt_ld_hi   = r_cnt_ld_hi;
   assign cnt_ld_data = r_cnt_ld_data;

endmodule
